// File: rtl/mult_issue_stage_if.sv
// Request/response handshake bundle between a producer/consumer and the
// multiply issue stage.
interface mult_issue_stage_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dataa;
  logic [WIDTH-1:0] in_datab;
  logic             in_signed;
  logic [1:0]       in_sel;
  logic [TAGW-1:0]  in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAGW-1:0]  out_tag;
  logic             out_ovf;

  // Producer of requests and consumer of results.
  modport master (
    output in_valid, in_dataa, in_datab, in_signed, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_ovf
  );

  // The issue stage itself.
  modport slave (
    input  in_valid, in_dataa, in_datab, in_signed, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_ovf
  );
endinterface

// File: rtl/mult_issue_stage.sv
// Issue/retire controller around a registered signed (W+1)x(W+1) multiplier.
// Operands are extended so one signed multiplier serves both signednesses; a
// shadow pipe tracks in-flight ops, and results land in an in-order FIFO whose
// free space is reserved at issue time, so the multiplier never has to stall.
module mult_issue_stage #(
  parameter int WIDTH    = 32,
  parameter int TAGW     = 5,
  parameter int MULT_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  mult_issue_stage_if.slave    bus,
  output logic [WIDTH:0]       mult_dataa,
  output logic [WIDTH:0]       mult_datab,
  output logic                 mult_clken,
  output logic                 mult_aclr,
  input  logic [2*WIDTH+1:0]   mult_result
);

  localparam int DEPTH = MULT_LAT + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(2*DEPTH + 1);
  localparam int ENTW  = WIDTH + TAGW + 1;
  localparam int LAST  = MULT_LAT - 1;

  logic                in_fire;
  logic [MULT_LAT-1:0] sh_valid;
  logic [MULT_LAT-1:0] sh_signed;
  logic [TAGW-1:0]     sh_tag [MULT_LAT];
  logic [1:0]          sh_sel [MULT_LAT];
  logic [CW-1:0]       inflight;

  logic [2*WIDTH-1:0]  prod;
  logic [WIDTH-1:0]    prod_lo;
  logic [WIDTH-1:0]    prod_hi;
  logic [WIDTH-1:0]    sel_result;
  logic                sel_ovf;

  logic [ENTW-1:0]     fifo_mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_count;
  logic [ENTW-1:0]     head;
  logic                push;
  logic                pop;

  // The top two product bits carry no information for W-bit results.
  logic                unused_prod_ext;
  assign unused_prod_ext = ^mult_result[2*WIDTH+1:2*WIDTH];

  assign in_fire    = bus.in_valid & bus.in_ready;
  assign mult_dataa = {bus.in_signed & bus.in_dataa[WIDTH-1], bus.in_dataa};
  assign mult_datab = {bus.in_signed & bus.in_datab[WIDTH-1], bus.in_datab};
  assign mult_clken = in_fire | (|sh_valid);
  assign mult_aclr  = reset;

  // Count ops still inside the multiplier; each already owns a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      inflight = inflight + CW'(sh_valid[i]);
    end
  end

  // Credit check uses registered state only, so out_ready never reaches in_ready.
  assign bus.in_ready = ~reset & ((fifo_count + inflight) < CW'(DEPTH));

  // Shadow valid bits move in lockstep with the multiplier's clock enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_valid <= '0;
    end else if (mult_clken) begin
      sh_valid[0] <= in_fire;
      for (int i = 1; i < MULT_LAT; i++) begin
        sh_valid[i] <= sh_valid[i-1];
      end
    end
  end

  // Shadow payload follows the valid bits; bubbles carry don't-care fields.
  always_ff @(posedge clock) begin
    if (mult_clken) begin
      sh_tag[0]    <= bus.in_tag;
      sh_sel[0]    <= bus.in_sel;
      sh_signed[0] <= bus.in_signed;
      for (int i = 1; i < MULT_LAT; i++) begin
        sh_tag[i]    <= sh_tag[i-1];
        sh_sel[i]    <= sh_sel[i-1];
        sh_signed[i] <= sh_signed[i-1];
      end
    end
  end

  assign prod    = mult_result[2*WIDTH-1:0];
  assign prod_lo = prod[WIDTH-1:0];
  assign prod_hi = prod[2*WIDTH-1:WIDTH];

  // Pick LO/HI/saturated-LO for the op leaving the multiplier this cycle.
  always_comb begin
    sel_result = prod_lo;
    sel_ovf    = 1'b0;
    case (sh_sel[LAST])
      2'd1: sel_result = prod_hi;
      2'd2: begin
        if (sh_signed[LAST]) begin
          // Signed fit in W bits means the top W+1 product bits all agree.
          if (!((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]))) begin
            sel_ovf    = 1'b1;
            sel_result = prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end else if (|prod_hi) begin
          sel_ovf    = 1'b1;
          sel_result = '1;
        end
      end
      default: sel_result = prod_lo;
    endcase
  end

  assign push = sh_valid[LAST] & mult_clken;
  assign pop  = bus.out_valid & bus.out_ready;

  // FIFO pointers and occupancy; reset discards everything buffered.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage: {ovf, tag, result}.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {sel_ovf, sh_tag[LAST], sel_result};
    end
  end

  assign head           = fifo_mem[rd_ptr];
  assign bus.out_valid  = ~reset & (fifo_count != '0);
  assign bus.out_result = bus.out_valid ? head[WIDTH-1:0]           : '0;
  assign bus.out_tag    = bus.out_valid ? head[WIDTH+TAGW-1:WIDTH]  : '0;
  assign bus.out_ovf    = bus.out_valid ? head[ENTW-1]              : 1'b0;

endmodule

// File: tb/tb_mult_issue_stage.sv
// Self-checking bench for mult_issue_stage with a behavioural multiplier and
// an arithmetic reference model of the result selection.
module tb_mult_issue_stage;
  localparam int W     = 32;
  localparam int TW    = 5;
  localparam int LAT   = 1;
  localparam int DEPTH = LAT + 2;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ovf;
    logic [31:0] cyc;
  } rec_t;

  logic clock = 1'b0;
  logic reset;
  logic [W:0]     mult_dataa;
  logic [W:0]     mult_datab;
  logic           mult_clken;
  logic           mult_aclr;
  logic [2*W+1:0] mult_result;

  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] cyc = 0;
  rec_t exp_q[$];
  rec_t got_q[$];

  always #5 clock = ~clock;

  mult_issue_stage_if #(.WIDTH(W), .TAGW(TW)) bus ();

  mult_issue_stage #(.WIDTH(W), .TAGW(TW), .MULT_LAT(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .mult_dataa  (mult_dataa),
    .mult_datab  (mult_datab),
    .mult_clken  (mult_clken),
    .mult_aclr   (mult_aclr),
    .mult_result (mult_result)
  );

  // Behavioural stand-in for the registered signed multiplier.
  logic [2*W+1:0] mpipe [LAT];

  function automatic logic [2*W+1:0] smul(input logic [W:0] a, input logic [W:0] b);
    logic signed [2*W+1:0] sa;
    logic signed [2*W+1:0] sb;
    sa = {{(W+1){a[W]}}, a};
    sb = {{(W+1){b[W]}}, b};
    return sa * sb;
  endfunction

  always @(posedge clock) begin
    if (mult_aclr) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else if (mult_clken) begin
      mpipe[0] <= smul(mult_dataa, mult_datab);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mult_result = mpipe[LAT-1];

  // Reference: full-precision arithmetic, then range tests for saturation.
  function automatic rec_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn, input logic [1:0] sel,
                                  input logic [4:0] tag, input logic [31:0] c);
    longint          sp;
    longint unsigned up;
    logic [63:0]     p;
    rec_t            r;
    sp = 0;
    up = 0;
    if (sgn) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p  = sp;
    end else begin
      up = 64'(a) * 64'(b);
      p  = up;
    end
    r.res = p[31:0];
    r.ovf = 1'b0;
    r.tag = tag;
    r.cyc = c;
    if (sel == 2'd1) begin
      r.res = p[63:32];
    end else if (sel == 2'd2) begin
      if (sgn) begin
        if (sp > 64'sd2147483647) begin
          r.res = 32'h7FFF_FFFF;
          r.ovf = 1'b1;
        end else if (sp < -64'sd2147483648) begin
          r.res = 32'h8000_0000;
          r.ovf = 1'b1;
        end
      end else if (up > 64'h0000_0000_FFFF_FFFF) begin
        r.res = 32'hFFFF_FFFF;
        r.ovf = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Record every accepted request (as a model prediction) and every pop.
  always @(negedge clock) begin
    rec_t g;
    #4;
    if (!reset && bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_op(bus.in_dataa, bus.in_datab, bus.in_signed,
                             bus.in_sel, bus.in_tag, cyc));
    if (bus.out_valid && bus.out_ready) begin
      g.res = bus.out_result;
      g.tag = bus.out_tag;
      g.ovf = bus.out_ovf;
      g.cyc = cyc;
      got_q.push_back(g);
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [1:0] sel, input logic [4:0] tag);
    bus.in_valid  = v;
    bus.in_dataa  = a;
    bus.in_datab  = b;
    bus.in_signed = s;
    bus.in_sel    = sel;
    bus.in_tag    = tag;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    drive(1'b1, 32'd5, 32'd6, 1'b0, 2'd0, 5'd3);
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      #4;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
      end
      n_checks++;
      if ({bus.out_valid, bus.out_result, bus.out_tag, bus.out_ovf} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs: got valid=%b result=%h tag=%h ovf=%b expected all 0",
                 bus.out_valid, bus.out_result, bus.out_tag, bus.out_ovf);
      end
      n_checks++;
      if (mult_aclr !== 1'b1) begin
        n_errors++; $display("FAIL reset_aclr: got %b expected 1", mult_aclr);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #4;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL reset_no_fire: got %0d accepts expected 0", exp_q.size());
    end
    n_checks++;
    if (mult_aclr !== 1'b0) begin
      n_errors++; $display("FAIL post_reset_aclr: got %b expected 0", mult_aclr);
    end
  endtask

  task automatic test_signed_lo_hi();
    exp_q.delete(); got_q.delete();
    bus.out_ready = 1'b1;
    @(negedge clock); drive(1'b1, -32'sd3, 32'd7, 1'b1, 2'd0, 5'd1);
    @(negedge clock); drive(1'b1, -32'sd3, 32'd7, 1'b1, 2'd1, 5'd2);
    @(negedge clock); bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < 2; k++) @(negedge clock);
    n_checks++;
    if (got_q.size() != 2) begin
      n_errors++; $display("FAIL signed_count: got %0d results expected 2", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0].res !== 32'hFFFF_FFEB || got_q[0].tag !== 5'd1) begin
        n_errors++; $display("FAIL signed_lo: got %h/tag%0d expected ffffffeb/tag1",
                             got_q[0].res, got_q[0].tag);
      end
      n_checks++;
      if (got_q[1].res !== 32'hFFFF_FFFF || got_q[1].tag !== 5'd2) begin
        n_errors++; $display("FAIL signed_hi: got %h/tag%0d expected ffffffff/tag2",
                             got_q[1].res, got_q[1].tag);
      end
      n_checks++;
      if (got_q[0].cyc - exp_q[0].cyc !== 32'd2) begin
        n_errors++; $display("FAIL signed_latency: got %0d expected 2",
                             got_q[0].cyc - exp_q[0].cyc);
      end
      n_checks++;
      if (got_q[1].cyc - got_q[0].cyc !== 32'd1) begin
        n_errors++; $display("FAIL signed_back_to_back: got gap %0d expected 1",
                             got_q[1].cyc - got_q[0].cyc);
      end
    end
  endtask

  task automatic test_unsigned_and_satlo();
    logic [31:0] ta [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                            32'h8000_0000, -32'sd4, 32'h0001_0000};
    logic [31:0] tb [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                            32'hFFFF_FFFF, 32'd5, 32'h0001_0000};
    logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  tl [6] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [31:0] er [6] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'h7FFF_FFFF,
                            32'h7FFF_FFFF, 32'hFFFF_FFEC, 32'hFFFF_FFFF};
    logic        eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_q.delete(); got_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      drive(1'b1, ta[i], tb[i], ts[i], tl[i], 5'(i + 10));
    end
    @(negedge clock); bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < 6; k++) @(negedge clock);
    n_checks++;
    if (got_q.size() != 6) begin
      n_errors++; $display("FAIL sat_count: got %0d results expected 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (got_q[i].res !== er[i] || got_q[i].ovf !== eo[i] || got_q[i].tag !== 5'(i + 10)) begin
          n_errors++;
          $display("FAIL sat_case%0d: got %h ovf=%b tag=%0d expected %h ovf=%b tag=%0d",
                   i, got_q[i].res, got_q[i].ovf, got_q[i].tag, er[i], eo[i], i + 10);
        end
        n_checks++;
        if (got_q[i].res !== exp_q[i].res || got_q[i].ovf !== exp_q[i].ovf) begin
          n_errors++;
          $display("FAIL sat_model%0d: got %h ovf=%b expected %h ovf=%b",
                   i, got_q[i].res, got_q[i].ovf, exp_q[i].res, exp_q[i].ovf);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int first_pop;
    acc = 0;
    first_pop = -1;
    exp_q.delete(); got_q.delete();
    @(negedge clock);
    bus.out_ready = 1'b0;
    drive(1'b1, $urandom, $urandom, 1'b1, 2'd0, 5'd0);
    #4;
    if (bus.in_valid && bus.in_ready) acc++;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      bus.in_tag = 5'(acc);
      #4;
      if (bus.in_valid && bus.in_ready) acc++;
    end
    n_checks++;
    if (acc != DEPTH) begin
      n_errors++; $display("FAIL bp_accepts: got %0d expected %0d", acc, DEPTH);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL bp_in_ready_low: got %b expected 0", bus.in_ready);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      bus.out_ready = 1'b1;
      if (acc >= 4) bus.in_valid = 1'b0;
      bus.in_tag = 5'(acc);
      #4;
      if (first_pop < 0 && bus.out_valid) first_pop = int'(cyc);
      if (bus.in_valid && bus.in_ready) acc++;
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < 4; k++) @(negedge clock);
    n_checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      n_errors++; $display("FAIL bp_count: got %0d pops %0d accepts expected 4",
                           got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_q[i].tag !== 5'(i) || got_q[i].res !== exp_q[i].res) begin
          n_errors++; $display("FAIL bp_order%0d: got tag%0d %h expected tag%0d %h",
                               i, got_q[i].tag, got_q[i].res, i, exp_q[i].res);
        end
      end
      n_checks++;
      if (int'(exp_q[3].cyc) != first_pop + 1) begin
        n_errors++; $display("FAIL bp_refill: got fire cycle %0d expected %0d",
                             exp_q[3].cyc, first_pop + 1);
      end
    end
  endtask

  task automatic test_midflight_reset();
    int seen_valid;
    seen_valid = 0;
    exp_q.delete(); got_q.delete();
    bus.out_ready = 1'b1;
    @(negedge clock); drive(1'b1, 32'd11, 32'd13, 1'b0, 2'd0, 5'd5);
    @(negedge clock); drive(1'b1, 32'd17, 32'd19, 1'b1, 2'd0, 5'd6);
    @(negedge clock); bus.in_valid = 1'b0; reset = 1'b1;
    #4;
    if (bus.out_valid) seen_valid++;
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #4;
      if (bus.out_valid) seen_valid++;
      @(negedge clock);
    end
    n_checks++;
    if (seen_valid != 0 || got_q.size() != 0) begin
      n_errors++; $display("FAIL midreset_flush: got %0d valid cycles %0d pops expected 0",
                           seen_valid, got_q.size());
    end
    exp_q.delete(); got_q.delete();
    drive(1'b1, 32'hFFFF_FFF0, 32'd3, 1'b1, 2'd0, 5'd9);
    @(negedge clock); bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < 1; k++) @(negedge clock);
    n_checks++;
    if (got_q.size() != 1) begin
      n_errors++; $display("FAIL midreset_new_count: got %0d expected 1", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0].res !== 32'hFFFF_FFD0 || got_q[0].tag !== 5'd9
          || got_q[0].cyc - exp_q[0].cyc !== 32'd2) begin
        n_errors++; $display("FAIL midreset_new_op: got %h tag%0d lat %0d expected ffffffd0 tag9 lat 2",
                             got_q[0].res, got_q[0].tag, got_q[0].cyc - exp_q[0].cyc);
      end
    end
  endtask

  task automatic test_random();
    logic        hold;
    logic [37:0] held;
    hold = 1'b0;
    held = '0;
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      drive($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
            1'($urandom), 2'($urandom), 5'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #4;
      if (hold) begin
        n_checks++;
        if (!bus.out_valid || {bus.out_result, bus.out_tag, bus.out_ovf} !== held) begin
          n_errors++; $display("FAIL rand_hold_stable: got valid=%b %h expected valid=1 %h",
                               bus.out_valid, {bus.out_result, bus.out_tag, bus.out_ovf}, held);
        end
      end
      hold = bus.out_valid & ~bus.out_ready;
      held = {bus.out_result, bus.out_tag, bus.out_ovf};
    end
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) @(negedge clock);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL rand_count: got %0d results expected %0d",
                           got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i].res !== exp_q[i].res || got_q[i].tag !== exp_q[i].tag
            || got_q[i].ovf !== exp_q[i].ovf) begin
          n_errors++; $display("FAIL rand_result%0d: got %h/%0d/%b expected %h/%0d/%b", i,
                               got_q[i].res, got_q[i].tag, got_q[i].ovf,
                               exp_q[i].res, exp_q[i].tag, exp_q[i].ovf);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 2'd0, '0);
    test_reset();
    test_signed_lo_hi();
    test_unsigned_and_satlo();
    test_backpressure();
    test_midflight_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
